// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet/IPv4/UDP transmit framer.
package eth_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StCsum,
    StPreamble,
    StHeader,
    StPayload,
    StPad,
    StFcs,
    StIfg,
    StRearm
  } state_e;

  localparam logic [7:0]  PreambleByte  = 8'h55;
  localparam logic [7:0]  SfdByte       = 8'hD5;
  localparam logic [15:0] EtherTypeIpv4 = 16'h0800;
  localparam logic [7:0]  IpProtoUdp    = 8'h11;
  localparam logic [15:0] IpFlagsFrag   = 16'h4000;

  // Frame byte offsets, counted from the first preamble byte.
  localparam logic [10:0] EthOffset     = 11'd8;
  localparam logic [10:0] IpOffset      = 11'd22;
  localparam logic [10:0] UdpOffset     = 11'd42;
  localparam logic [10:0] PayloadOffset = 11'd50;

  localparam logic [10:0] MaxUdpLen     = 11'd1472;
  localparam logic [10:0] MinPayload    = 11'd18;
  localparam logic [10:0] IpHdrWords    = 11'd10;

  // Two end-around-carry folds of the 20-bit word sum, then ones' complement.
  function automatic logic [15:0] csum_fold(input logic [19:0] acc);
    logic [16:0] s1;
    logic [15:0] s2;
    s1 = {1'b0, acc[15:0]} + {13'd0, acc[19:16]};
    s2 = s1[15:0] + {15'd0, s1[16]};
    return ~s2;
  endfunction

endpackage

// File: rtl/crc32_eth.sv
// Byte-wide reflected CRC-32 (poly 04C11DB7) with synchronous init and enable.
module crc32_eth (
  input  logic        tx_clock,
  input  logic        Tx_reset,
  input  logic        init,
  input  logic        enable,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  logic [31:0] crc_q, crc_d, crc_step;

  always_comb begin
    crc_step = crc_q ^ {24'd0, data};
    for (int i = 0; i < 8; i++) begin
      crc_step = crc_step[0] ? ((crc_step >> 1) ^ 32'hEDB88320) : (crc_step >> 1);
    end
    crc_d = crc_q;
    if (init) begin
      crc_d = 32'hFFFF_FFFF;
    end else if (enable) begin
      crc_d = crc_step;
    end
  end

  always_ff @(posedge tx_clock or posedge Tx_reset) begin
    if (Tx_reset) begin
      crc_q <= 32'hFFFF_FFFF;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/udp_ip_framer.sv
// Builds preamble, Ethernet II, IPv4 and UDP headers around a UDP payload, pads to the
// minimum frame size and appends the FCS on a byte-wide GMII-style transmit stream.
module udp_ip_framer
  import eth_pkg::*;
#(
  parameter logic [15:0] FROM_PORT  = 16'd1024,
  parameter logic [7:0]  TTL        = 8'h80,
  parameter int unsigned IFG_CYCLES = 12
) (
  input  logic        tx_clock,
  input  logic        Tx_reset,
  input  logic        udp_tx_request,
  input  logic [10:0] udp_tx_length,
  input  logic [7:0]  udp_tx_data,
  output logic        udp_tx_enable,
  output logic        udp_tx_active,
  input  logic [47:0] This_MAC,
  input  logic [31:0] This_IP,
  input  logic [47:0] to_mac,
  input  logic [31:0] to_ip,
  input  logic [15:0] to_port,
  output logic [7:0]  phy_tx_data,
  output logic        phy_tx_en,
  output logic        length_err
);

  state_e      state_q, state_d;
  logic [10:0] cnt_q, cnt_d;
  logic [10:0] len_q, len_d;
  logic [47:0] dst_mac_q, dst_mac_d, src_mac_q, src_mac_d;
  logic [31:0] src_ip_q, src_ip_d, dst_ip_q, dst_ip_d;
  logic [15:0] dst_port_q, dst_port_d;
  logic [19:0] acc_q, acc_d;
  logic [15:0] ident_q, ident_d;
  logic [7:0]  phy_data_q, phy_data_d;
  logic        phy_en_q, phy_en_d;
  logic        enable_q, enable_d;
  logic        len_err_q, len_err_d;

  logic        crc_init, crc_en;
  logic [31:0] crc, fcs;
  logic [15:0] tot_len, udp_len, ip_csum, csum_word;
  logic [335:0] hdr;
  logic [5:0]  hdr_idx;
  logic [7:0]  hdr_byte, fcs_byte;

  assign tot_len = {5'd0, len_q} + 16'd28;
  assign udp_len = {5'd0, len_q} + 16'd8;
  assign ip_csum = csum_fold(acc_q);
  assign fcs     = ~crc;

  // Bytes 8..49, most significant byte first on the wire.
  assign hdr = {dst_mac_q, src_mac_q, EtherTypeIpv4,
                8'h45, 8'h00, tot_len, ident_q, IpFlagsFrag, TTL, IpProtoUdp, ip_csum,
                src_ip_q, dst_ip_q,
                FROM_PORT, dst_port_q, udp_len, 16'h0000};

  assign hdr_idx  = 6'(PayloadOffset - 11'd1 - cnt_q);
  assign hdr_byte = hdr[{hdr_idx, 3'b000} +: 8];
  assign fcs_byte = fcs[{cnt_q[1:0], 3'b000} +: 8];

  // IPv4 header words in wire order; word 5 is the checksum field, summed as zero.
  always_comb begin
    case (cnt_q[3:0])
      4'd0:    csum_word = 16'h4500;
      4'd1:    csum_word = tot_len;
      4'd2:    csum_word = ident_q;
      4'd3:    csum_word = IpFlagsFrag;
      4'd4:    csum_word = {TTL, IpProtoUdp};
      4'd6:    csum_word = src_ip_q[31:16];
      4'd7:    csum_word = src_ip_q[15:0];
      4'd8:    csum_word = dst_ip_q[31:16];
      4'd9:    csum_word = dst_ip_q[15:0];
      default: csum_word = 16'h0000;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    dst_mac_d  = dst_mac_q;
    src_mac_d  = src_mac_q;
    src_ip_d   = src_ip_q;
    dst_ip_d   = dst_ip_q;
    dst_port_d = dst_port_q;
    acc_d      = acc_q;
    ident_d    = ident_q;
    phy_data_d = 8'h00;
    phy_en_d   = 1'b0;
    enable_d   = 1'b0;
    len_err_d  = 1'b0;
    crc_init   = 1'b0;
    crc_en     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (udp_tx_request) begin
          if (udp_tx_length != 11'd0 && udp_tx_length <= MaxUdpLen) begin
            len_d      = udp_tx_length;
            dst_mac_d  = to_mac;
            src_mac_d  = This_MAC;
            src_ip_d   = This_IP;
            dst_ip_d   = to_ip;
            dst_port_d = to_port;
            acc_d      = '0;
            cnt_d      = '0;
            state_d    = StCsum;
          end else begin
            len_err_d = 1'b1;
            state_d   = StRearm;
          end
        end
      end

      StCsum: begin
        crc_init = 1'b1;
        acc_d    = acc_q + {4'd0, csum_word};
        cnt_d    = cnt_q + 11'd1;
        if (cnt_q == IpHdrWords - 11'd1) begin
          cnt_d   = '0;
          state_d = StPreamble;
        end
      end

      StPreamble: begin
        phy_en_d   = 1'b1;
        phy_data_d = (cnt_q == EthOffset - 11'd1) ? SfdByte : PreambleByte;
        cnt_d      = cnt_q + 11'd1;
        if (cnt_q == EthOffset - 11'd1) begin
          state_d = StHeader;
        end
      end

      StHeader: begin
        phy_en_d   = 1'b1;
        phy_data_d = hdr_byte;
        crc_en     = 1'b1;
        // Grant lands on the cycle byte 48 is on the wire, two ahead of the payload.
        enable_d   = (cnt_q == PayloadOffset - 11'd2);
        cnt_d      = cnt_q + 11'd1;
        if (cnt_q == PayloadOffset - 11'd1) begin
          state_d = StPayload;
        end
      end

      StPayload: begin
        phy_en_d   = 1'b1;
        phy_data_d = udp_tx_data;
        crc_en     = 1'b1;
        cnt_d      = cnt_q + 11'd1;
        if (cnt_q == PayloadOffset + len_q - 11'd1) begin
          if (len_q < MinPayload) begin
            state_d = StPad;
          end else begin
            state_d = StFcs;
            cnt_d   = '0;
          end
        end
      end

      StPad: begin
        phy_en_d = 1'b1;
        crc_en   = 1'b1;
        cnt_d    = cnt_q + 11'd1;
        if (cnt_q == PayloadOffset + MinPayload - 11'd1) begin
          state_d = StFcs;
          cnt_d   = '0;
        end
      end

      StFcs: begin
        phy_en_d   = 1'b1;
        phy_data_d = fcs_byte;
        cnt_d      = cnt_q + 11'd1;
        if (cnt_q == 11'd3) begin
          state_d = StIfg;
          cnt_d   = '0;
          ident_d = ident_q + 16'd1;
        end
      end

      StIfg: begin
        cnt_d = cnt_q + 11'd1;
        if (cnt_q == 11'(IFG_CYCLES - 1)) begin
          state_d = StRearm;
          cnt_d   = '0;
        end
      end

      StRearm: begin
        if (!udp_tx_request) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge tx_clock or posedge Tx_reset) begin
    if (Tx_reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      len_q      <= '0;
      dst_mac_q  <= '0;
      src_mac_q  <= '0;
      src_ip_q   <= '0;
      dst_ip_q   <= '0;
      dst_port_q <= '0;
      acc_q      <= '0;
      ident_q    <= '0;
      phy_data_q <= '0;
      phy_en_q   <= 1'b0;
      enable_q   <= 1'b0;
      len_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      dst_mac_q  <= dst_mac_d;
      src_mac_q  <= src_mac_d;
      src_ip_q   <= src_ip_d;
      dst_ip_q   <= dst_ip_d;
      dst_port_q <= dst_port_d;
      acc_q      <= acc_d;
      ident_q    <= ident_d;
      phy_data_q <= phy_data_d;
      phy_en_q   <= phy_en_d;
      enable_q   <= enable_d;
      len_err_q  <= len_err_d;
    end
  end

  crc32_eth u_crc (
    .tx_clock (tx_clock),
    .Tx_reset (Tx_reset),
    .init     (crc_init),
    .enable   (crc_en),
    .data     (phy_data_d),
    .crc      (crc)
  );

  assign phy_tx_data   = phy_data_q;
  assign phy_tx_en     = phy_en_q;
  assign udp_tx_enable = enable_q;
  assign udp_tx_active = (state_q == StPayload);
  assign length_err    = len_err_q;

endmodule
